// File: rtl/mem_access_if.sv
// Request/response handshake and RAM port bundle for the load/store unit.
// slave is the load/store unit's view; master is the pipeline/RAM side's view.
interface mem_access_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_error;
  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_di;
  logic [31:0]           ram_do;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready, ram_do,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, ram_en, ram_we, ram_addr, ram_di
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready, ram_do,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, ram_en, ram_we, ram_addr, ram_di
  );
endinterface

// File: rtl/mem_access.sv
// Non-pipelined load/store unit driving one port of a byte-enable data RAM.
// Define MISALIGN_TRAP_EN to flag misaligned H/HU/W accesses as errors instead of force-aligning.
module mem_access #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic         clk,
  input  logic         reset,
  mem_access_if.slave  bus
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [2:0]  funct3_p0;
  logic [1:0]  a_p0;
  logic        write_p0;
  logic        err_p0;
  logic        accept;
  logic        illegal;
  logic        unused_addr;

  function automatic logic req_illegal(input logic wr, input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    logic misaligned;
    bad        = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wr && f3[2]);
    misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3 == 3'b010) && (a != 2'b00));
    return bad || (TRAP_EN && misaligned);
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = d[8*a +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  return 32'(b);
      3'b100:  return {24'b0, b};
      3'b001:  return 32'(h);
      3'b101:  return {16'b0, h};
      default: return d;
    endcase
  endfunction

  assign bus.req_ready = (state == IDLE) && !reset;
  assign bus.ram_addr  = bus.req_addr[ADDR_WIDTH+1:2];
  assign bus.ram_di    = store_data(bus.req_funct3, bus.req_wdata);
  assign unused_addr   = ^{bus.req_addr[31:ADDR_WIDTH+2]};

  // RAM port is driven combinationally only during the accept cycle.
  always_comb begin
    accept     = bus.req_valid && bus.req_ready;
    illegal    = req_illegal(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);
    bus.ram_en = accept && !illegal;
    bus.ram_we = 4'b0000;
    if (accept && !illegal && bus.req_write)
      bus.ram_we = byte_en(bus.req_funct3, bus.req_addr[1:0]);
  end

  // Stage p0: request attributes captured on the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      funct3_p0 <= bus.req_funct3;
      a_p0      <= bus.req_addr[1:0];
      write_p0  <= bus.req_write;
      err_p0    <= illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'b0;
      bus.rsp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) state <= WAIT;
        WAIT: begin
          bus.rsp_rdata <= (err_p0 || write_p0) ? 32'b0 : load_format(funct3_p0, a_p0, bus.ram_do);
          bus.rsp_error <= err_p0;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
